// File: rtl/v_seq_pkg.sv
// Shared types for the vector issue scoreboard.
// Slot states, FU ids and the instruction status table entry.
package v_seq_pkg;
    localparam int NO_OF_SLOTS = 8;
    localparam int NO_OF_VREGS = 32;
    localparam int NO_OF_FU    = 4;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } slot_state_e;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_RED = 2'd3
    } fu_id_e;

    typedef struct packed {
        fu_id_e      fu;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic        wr;
        logic        rd1;
        logic        rd2;
        slot_state_e state;
    } ist_entry_t;
endpackage

// File: rtl/v_hazard_check.sv
// Issue gate for the candidate slot: RAW, WAW and structural hazards.
// Purely combinational, looks only at registered busy status.
module v_hazard_check
    import v_seq_pkg::*;
(
    input  ist_entry_t             entry,
    input  logic [NO_OF_VREGS-1:0] reg_busy,
    input  logic [NO_OF_FU-1:0]    fu_busy,
    output logic                   iss_valid
);
    logic raw1;
    logic raw2;
    logic waw;
    logic strct;

    always_comb begin
        raw1      = entry.rd1 && reg_busy[entry.vs1];
        raw2      = entry.rd2 && reg_busy[entry.vs2];
        waw       = entry.wr && reg_busy[entry.vd];
        strct     = fu_busy[entry.fu];
        iss_valid = (entry.state == WAIT) && !raw1 && !raw2
                    && !waw && !strct;
    end
endmodule

// File: rtl/v_scoreboard.sv
// In-order issue controller for the vector pipeline.
// Circular status table with enqueue, fire, writeback and retire.
module v_scoreboard #(
    parameter int NO_OF_SLOTS = 8,
    parameter int NO_OF_FU    = 4,
    parameter int NO_OF_VREGS = 32
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [1:0]                         in_fu,
    input  logic [4:0]                         in_vd,
    input  logic [4:0]                         in_vs1,
    input  logic [4:0]                         in_vs2,
    input  logic                               in_wr,
    input  logic                               in_rd1,
    input  logic                               in_rd2,
    output logic                               iss_valid,
    output logic [1:0]                         iss_fu,
    output logic [$clog2(NO_OF_SLOTS)-1:0]     iss_tag,
    output logic [4:0]                         iss_vd,
    output logic [4:0]                         iss_vs1,
    output logic [4:0]                         iss_vs2,
    input  logic [NO_OF_FU-1:0]                fu_ready,
    input  logic                               wb_valid,
    input  logic [$clog2(NO_OF_SLOTS)-1:0]     wb_tag,
    output logic [NO_OF_VREGS-1:0]             reg_busy,
    output logic [NO_OF_FU-1:0]                fu_busy,
    output logic [$clog2(NO_OF_SLOTS+1)-1:0]   count,
    output logic                               wb_err
);
    import v_seq_pkg::*;

    localparam int TW = $clog2(NO_OF_SLOTS);
    localparam int CW = $clog2(NO_OF_SLOTS + 1);

    ist_entry_t              slots [NO_OF_SLOTS];
    logic [TW-1:0]           tail;
    logic [TW-1:0]           iss;
    logic [TW-1:0]           head;
    ist_entry_t              cand;
    ist_entry_t              wb_e;
    logic                    hz_ok;
    logic                    enq;
    logic                    fire;
    logic                    wb_hit;
    logic                    retire;
    logic [NO_OF_VREGS-1:0]  set_reg;
    logic [NO_OF_VREGS-1:0]  clr_reg;
    logic [NO_OF_FU-1:0]     set_fu;
    logic [NO_OF_FU-1:0]     clr_fu;

    assign cand = slots[iss];
    assign wb_e = slots[wb_tag];

    v_hazard_check u_hz (
        .entry     (cand),
        .reg_busy  (reg_busy),
        .fu_busy   (fu_busy),
        .iss_valid (hz_ok)
    );

    assign in_ready  = (count != CW'(NO_OF_SLOTS));
    assign iss_valid = hz_ok;
    assign iss_fu    = cand.fu;
    assign iss_tag   = iss;
    assign iss_vd    = cand.vd;
    assign iss_vs1   = cand.vs1;
    assign iss_vs2   = cand.vs2;

    assign enq    = in_valid && in_ready;
    assign fire   = iss_valid && fu_ready[cand.fu];
    assign wb_hit = wb_valid && (wb_e.state == EXEC);
    assign retire = (slots[head].state == DONE);

    // Clear mask is applied before the set mask, so a same-cycle set wins.
    always_comb begin
        set_reg = '0;
        clr_reg = '0;
        set_fu  = '0;
        clr_fu  = '0;
        if (fire) begin
            set_fu[cand.fu] = 1'b1;
            if (cand.wr) set_reg[cand.vd] = 1'b1;
        end
        if (wb_hit) begin
            clr_fu[wb_e.fu] = 1'b1;
            if (wb_e.wr) clr_reg[wb_e.vd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NO_OF_SLOTS; i++) slots[i] <= '0;
            tail     <= '0;
            iss      <= '0;
            head     <= '0;
            count    <= '0;
            reg_busy <= '0;
            fu_busy  <= '0;
            wb_err   <= 1'b0;
        end else begin
            // Each event targets a slot in a distinct state, so no overlap.
            if (enq) begin
                slots[tail] <= '{fu: fu_id_e'(in_fu), vd: in_vd,
                                 vs1: in_vs1, vs2: in_vs2, wr: in_wr,
                                 rd1: in_rd1, rd2: in_rd2, state: WAIT};
                tail <= tail + 1'b1;
            end
            if (fire) begin
                slots[iss].state <= EXEC;
                iss <= iss + 1'b1;
            end
            if (wb_hit) slots[wb_tag].state <= DONE;
            else if (wb_valid) wb_err <= 1'b1;
            if (retire) begin
                slots[head].state <= FREE;
                head <= head + 1'b1;
            end
            count    <= count + CW'(enq) - CW'(retire);
            reg_busy <= (reg_busy & ~clr_reg) | set_reg;
            fu_busy  <= (fu_busy & ~clr_fu) | set_fu;
        end
    end
endmodule

// File: doc/v_scoreboard.md
# v_scoreboard

- In-order issue controller for the vector pipeline.
- Accepts decoded vector instructions into an 8-slot circular instruction status table and tracks each slot's stage.
- Issues the oldest unissued instruction to one of four functional units once RAW, WAW and structural hazards clear; retires on writeback.
- Sits between the vector decoder and the functional-unit datapath; owns the register result status and functional unit status.

## Interface
- NO_OF_SLOTS, 8, table depth (power of two)
- NO_OF_FU, 4, number of functional units
- NO_OF_VREGS, 32, vector register count
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoder has an instruction
- in_ready  out  1  slot free; enqueue on in_valid & in_ready
- in_fu  in  2  target functional unit
- in_vd, in_vs1, in_vs2  in  5 each  destination/source registers
- in_wr  in  1  instruction writes vd
- in_rd1, in_rd2  in  1 each  vs1/vs2 are read
- iss_valid  out  1  head-of-issue candidate is hazard-free
- iss_fu  out  2; iss_tag  out  3; iss_vd/iss_vs1/iss_vs2  out  5 each  issued instruction fields
- fu_ready  in  NO_OF_FU  per-FU accept; fire = iss_valid & fu_ready[iss_fu]
- wb_valid  in  1; wb_tag  in  3  completion of slot wb_tag
- reg_busy  out  NO_OF_VREGS  register result status
- fu_busy  out  NO_OF_FU  functional unit status
- count  out  4  occupied slots, 0..8
- wb_err  out  1  sticky: writeback to a slot not in EXEC

## Operation
- Slot states: FREE -> WAIT (enqueued) -> EXEC (fired) -> DONE (writeback) -> FREE (retired).
- Pointers tail/iss/head are 3-bit, wrap modulo 8. Slot index is the tag.
- Enqueue: write fields to slot[tail], state WAIT, tail++.
- Candidate is slot[iss] when its state is WAIT.
- iss_valid = 1 when:
  - no vs1 read to a busy register (reg_busy[vs1] while rd1);
  - no vs2 read to a busy register (reg_busy[vs2] while rd2);
  - vd is not busy while wr;
  - fu_busy[fu] is clear.
- Fire:
  - slot state EXEC, iss++;
  - fu_busy[fu] set;
  - reg_busy[vd] set if wr.
- Writeback: slot[wb_tag] in EXEC moves to DONE; clears fu_busy[fu] and clears reg_busy[vd] if wr. Any other state: ignored, wb_err set.
- Retire: slot[head] in DONE becomes FREE, head++. At most one retire per cycle, in program order.
- count is updated as +enq −retire. in_ready = (count != 8), from registered count.
- Hazard check uses registered status only; there is no bypass. A writeback releases a register or FU for issue starting the next cycle.
- Simultaneous events:
  - enqueue, fire, writeback and retire may all occur in one cycle;
  - wb clear and fire set never target the same reg_busy bit, because WAW blocks it;
  - if they target the same fu_busy bit (fire only sees it clear when the FU is idle), set wins.
- Full with retire in the same cycle: in_ready stays 0 that cycle; no cut-through.
- Empty: iss_valid = 0.
- Reset mid-operation clears all slots and status immediately; in-flight FU results after reset are ignored and set wb_err.

## Timing
- Reset values:
  - in_ready=1, iss_valid=0, count=0, wb_err=0;
  - reg_busy=0, fu_busy=0;
  - iss_* fields=0; all pointers 0.
- Enqueue at edge N: earliest iss_valid is in cycle N+1.
- Fire at edge M: reg_busy/fu_busy visible in cycle M+1.
- Writeback at edge W: busy bits clear in W+1; retire at edge W+1; count drops in W+2.
- iss_valid and iss_* are combinational from registered state. They must not depend on fu_ready (no combinational loop).

## Structure
- Package v_seq_pkg holds:
  - slot_state_e {FREE, WAIT, EXEC, DONE};
  - ist_entry_t struct (fu, vd, vs1, vs2, wr, rd1, rd2, state);
  - fu_id_e (FU_ALU=0, FU_MUL=1, FU_LSU=2, FU_RED=3);
  - NO_OF_SLOTS and NO_OF_VREGS constants.
- One sub-module, v_hazard_check: combinational. Inputs are the candidate entry, reg_busy and fu_busy; output is iss_valid.

## Test plan
- Reset mid-stream with 5 slots occupied -> count=0, reg_busy=0, in_ready=1 in the same cycle; a later wb_tag=2 sets wb_err.
- Enqueue 8 independent instructions, fu_ready=0 -> in_ready=0 after the 8th; 9th held; count=8.
- RAW: v3 written by MUL, then ALU reads v3 -> ALU fire occurs exactly 1 cycle after the MUL writeback; reg_busy[3] set then cleared.
- WAW plus structural: two writes to v5 targeting FU_ALU -> second fires only after wb_tag=0; fu_busy[0] toggles accordingly.
- Out-of-order writeback: tags 0,1 fired, wb_tag=1 then wb_tag=0 -> slot 1 stays DONE until slot 0 retires; head advances 0→1→2 on consecutive edges.
- Wrap: 12 sequential instructions through a 1-cycle FU -> tags wrap 7→0; count never exceeds 8; no wb_err.
